// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter sweep sequencer.
// States, sweep modes and power-on bound defaults.
package counter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] MODE_SAW_UP  = 2'b00;
    localparam logic [1:0] MODE_SAW_DN  = 2'b01;
    localparam logic [1:0] MODE_TRI     = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    // Default bounds are replicated across the count width: lo all-zero, hi all-one.
    localparam logic DEF_LO_BIT = 1'b0;
    localparam logic DEF_HI_BIT = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-clock tick every TICK_DIV clocks while not cleared.
// Shared by several board demos.
module tick_gen #(
    parameter int TICK_DIV = 500000
) (
    input  logic clock,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = !clr && (cnt == LAST);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for the 6-bit up/down counter datapath.
// Saw, triangle and single-shot sweeps between programmable bounds.
module counter_sweep_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH      = 6,
    parameter int TICK_DIV   = 500000,
    parameter int HOLD_TICKS = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [WIDTH-1:0] cfg_lo,
    input  logic [WIDTH-1:0] cfg_hi,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             wrap,
    output logic             cfg_err
);

    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_LAST =
        HW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [1:0]       state;
    logic [1:0]       mode;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [HW-1:0]    hold_cnt;
    logic             tick;
    logic             go;
    logic             at_end;
    logic [WIDTH-1:0] load_cnt;
    logic             load_dir;

    assign cfg_ready = (state == ST_IDLE);
    assign busy      = (state == ST_RUN) || (state == ST_HOLD);
    assign go        = start && !stop;
    assign at_end    = dir ? (count == lo) : (count == hi);
    assign load_dir  = (mode == MODE_SAW_DN);
    assign load_cnt  = load_dir ? hi : lo;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clock(clock),
        .rst_n(rst_n),
        .clr  (!busy),
        .tick (tick)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            dir      <= 1'b0;
            wrap     <= 1'b0;
            cfg_err  <= 1'b0;
            mode     <= MODE_SAW_UP;
            lo       <= {WIDTH{DEF_LO_BIT}};
            hi       <= {WIDTH{DEF_HI_BIT}};
            hold_cnt <= '0;
        end else begin
            wrap <= 1'b0;
            if (stop && state != ST_IDLE) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cfg_valid) begin
                            if (cfg_lo <= cfg_hi) begin
                                mode    <= cfg_mode;
                                lo      <= cfg_lo;
                                hi      <= cfg_hi;
                                cfg_err <= 1'b0;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                        if (go) begin
                            state <= ST_RUN;
                            count <= load_cnt;
                            dir   <= load_dir;
                        end
                    end
                    ST_DONE: begin
                        if (go) begin
                            state <= ST_RUN;
                            count <= load_cnt;
                            dir   <= load_dir;
                        end
                    end
                    ST_HOLD: begin
                        if (tick) begin
                            if (hold_cnt == HOLD_LAST)
                                state <= ST_RUN;
                            else
                                hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    ST_RUN: begin
                        if (tick) begin
                            unique case (mode)
                                MODE_SAW_UP: begin
                                    if (count < hi) begin
                                        count <= count + ONE;
                                    end else begin
                                        count <= lo;
                                        wrap  <= 1'b1;
                                    end
                                end
                                MODE_SAW_DN: begin
                                    if (count > lo) begin
                                        count <= count - ONE;
                                    end else begin
                                        count <= hi;
                                        wrap  <= 1'b1;
                                    end
                                end
                                MODE_TRI: begin
                                    if (at_end) begin
                                        dir  <= !dir;
                                        wrap <= 1'b1;
                                        // Without dwell, the turnaround also takes the first step back.
                                        if (HOLD_TICKS > 0) begin
                                            state    <= ST_HOLD;
                                            hold_cnt <= '0;
                                        end else if (dir && count < hi) begin
                                            count <= count + ONE;
                                        end else if (!dir && count > lo) begin
                                            count <= count - ONE;
                                        end
                                    end else begin
                                        count <= dir ? count - ONE : count + ONE;
                                    end
                                end
                                MODE_ONESHOT: begin
                                    if (count < hi) begin
                                        count <= count + ONE;
                                    end else begin
                                        wrap  <= 1'b1;
                                        state <= ST_DONE;
                                    end
                                end
                            endcase
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed cycle-by-cycle vectors for counter_sweep_ctrl.
// TICK_DIV=2, HOLD_TICKS=2.
module tb_counter_sweep_ctrl;

    typedef struct {
        logic       cv;
        logic [1:0] md;
        logic [5:0] lo;
        logic [5:0] hi;
        logic       st;
        logic       sp;
        logic [5:0] c;
        logic       d;
        logic       b;
        logic       w;
        logic       e;
        logic       r;
    } vec_t;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_mode = 2'b00;
    logic [5:0] cfg_lo = '0;
    logic [5:0] cfg_hi = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [5:0] count;
    logic       dir;
    logic       busy;
    logic       wrap;
    logic       cfg_err;

    int tests = 0;
    int fails = 0;
    vec_t vt[$];

    counter_sweep_ctrl #(
        .WIDTH(6),
        .TICK_DIV(2),
        .HOLD_TICKS(2)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode),
        .cfg_lo(cfg_lo),
        .cfg_hi(cfg_hi),
        .start(start),
        .stop(stop),
        .count(count),
        .dir(dir),
        .busy(busy),
        .wrap(wrap),
        .cfg_err(cfg_err)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(
        input logic cv, input logic [1:0] md,
        input logic [5:0] lo, input logic [5:0] hi,
        input logic st, input logic sp,
        input logic [5:0] c, input logic d, input logic b,
        input logic w, input logic e, input logic r);
        vec_t v;
        v.cv = cv; v.md = md; v.lo = lo; v.hi = hi;
        v.st = st; v.sp = sp; v.c = c; v.d = d;
        v.b = b; v.w = w; v.e = e; v.r = r;
        return v;
    endfunction

    // Idle-input vector: only expected outputs vary
    function automatic vec_t nx(
        input logic [5:0] c, input logic d, input logic b,
        input logic w, input logic e, input logic r);
        return mk(0, 0, 0, 0, 0, 0, c, d, b, w, e, r);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, ".count"}, count, v.c);
        chk({tag, ".dir"}, dir, v.d);
        chk({tag, ".busy"}, busy, v.b);
        chk({tag, ".wrap"}, wrap, v.w);
        chk({tag, ".cfg_err"}, cfg_err, v.e);
        chk({tag, ".cfg_ready"}, cfg_ready, v.r);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic cv, input logic [1:0] md,
                         input logic [5:0] lo, input logic [5:0] hi,
                         input logic st, input logic sp);
        cfg_valid = cv; cfg_mode = md; cfg_lo = lo; cfg_hi = hi;
        start = st; stop = sp;
    endtask

    initial begin
        // saw-up 3..5, cfg attempt during RUN, stop/start collisions
        vt.push_back(mk(1, 0, 3, 5, 0, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 3, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 3, 0, 1, 0, 0, 0));
        vt.push_back(nx(4, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 2, 0, 1, 0, 0, 4, 0, 1, 0, 0, 0));
        vt.push_back(nx(5, 0, 1, 0, 0, 0));
        vt.push_back(nx(5, 0, 1, 0, 0, 0));
        vt.push_back(nx(3, 0, 1, 1, 0, 0));
        vt.push_back(nx(3, 0, 1, 0, 0, 0));
        vt.push_back(nx(4, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 3, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 1));
        // rejected config keeps old one, then valid configs clear error
        vt.push_back(mk(1, 1, 9, 4, 0, 0, 3, 0, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 3, 0, 1, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 1));
        vt.push_back(mk(1, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 1));
        vt.push_back(mk(1, 2, 0, 2, 0, 0, 3, 0, 0, 0, 0, 1));
        // triangle 0..2 with two-tick dwell at each end
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        vt.push_back(nx(0, 0, 1, 0, 0, 0));
        vt.push_back(nx(1, 0, 1, 0, 0, 0));
        vt.push_back(nx(1, 0, 1, 0, 0, 0));
        vt.push_back(nx(2, 0, 1, 0, 0, 0));
        vt.push_back(nx(2, 0, 1, 0, 0, 0));
        vt.push_back(nx(2, 1, 1, 1, 0, 0));
        for (int i = 0; i < 5; i++) vt.push_back(nx(2, 1, 1, 0, 0, 0));
        vt.push_back(nx(1, 1, 1, 0, 0, 0));
        vt.push_back(nx(1, 1, 1, 0, 0, 0));
        vt.push_back(nx(0, 1, 1, 0, 0, 0));
        vt.push_back(nx(0, 1, 1, 0, 0, 0));
        vt.push_back(nx(0, 0, 1, 1, 0, 0));
        for (int i = 0; i < 5; i++) vt.push_back(nx(0, 0, 1, 0, 0, 0));
        vt.push_back(nx(1, 0, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        // single-shot 62..63, restart from DONE, stop from DONE
        vt.push_back(mk(1, 3, 62, 63, 0, 0, 1, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 62, 0, 1, 0, 0, 0));
        vt.push_back(nx(62, 0, 1, 0, 0, 0));
        vt.push_back(nx(63, 0, 1, 0, 0, 0));
        vt.push_back(nx(63, 0, 1, 0, 0, 0));
        vt.push_back(nx(63, 0, 0, 1, 0, 0));
        vt.push_back(nx(63, 0, 0, 0, 0, 0));
        vt.push_back(nx(63, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 62, 0, 1, 0, 0, 0));
        vt.push_back(nx(62, 0, 1, 0, 0, 0));
        vt.push_back(nx(63, 0, 1, 0, 0, 0));
        vt.push_back(nx(63, 0, 1, 0, 0, 0));
        vt.push_back(nx(63, 0, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 63, 0, 0, 0, 0, 1));
        // saw with lo == hi: constant count, wrap every tick
        vt.push_back(mk(1, 0, 7, 7, 0, 0, 63, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 7, 0, 1, 0, 0, 0));
        vt.push_back(nx(7, 0, 1, 0, 0, 0));
        vt.push_back(nx(7, 0, 1, 1, 0, 0));
        vt.push_back(nx(7, 0, 1, 0, 0, 0));
        vt.push_back(nx(7, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 1));

        #12 rst_n = 1'b1;
        step();
        check_all("reset", nx(0, 0, 0, 0, 0, 1));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].cv, vt[i].md, vt[i].lo, vt[i].hi, vt[i].st, vt[i].sp);
            step();
            check_all($sformatf("v%0d", i), vt[i]);
        end

        // saw-down 0..5 to count 4, then asynchronous reset mid-sweep
        drive(1, 1, 0, 5, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 0);
        step();
        check_all("sd_load", nx(5, 1, 1, 0, 0, 0));
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        check_all("sd_pre", nx(4, 1, 1, 0, 0, 0));
        rst_n = 1'b0;
        #1;
        check_all("async_rst", nx(0, 0, 0, 0, 0, 1));
        rst_n = 1'b1;

        // defaults restored: saw-up 0..63 must reach 63 then wrap to 0
        drive(0, 0, 0, 0, 1, 0);
        step();
        check_all("def_load", nx(0, 0, 1, 0, 0, 0));
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 126; i++) step();
        check_all("def_top", nx(63, 0, 1, 0, 0, 0));
        step();
        step();
        check_all("def_wrap", nx(0, 0, 1, 1, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
Sequencer for the board's 6-bit up/down counter datapath. It holds a loadable 6-bit count and steps it at a prescaled rate. It supports saw-up, saw-down, triangle and single-shot sweeps between programmable lo/hi bounds. Configuration uses a valid/ready handshake. The count output drives the scope/LED header directly.

Parameters:
WIDTH, 6, count width
TICK_DIV, 500000, clocks per step tick; 100 Hz at 50 MHz; minimum 1
HOLD_TICKS, 4, ticks to dwell at each triangle endpoint; 0 means no dwell

Ports:
clock  in  1  50 MHz system clock
rst_n  in  1  asynchronous, active-low reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration can be accepted
cfg_mode  in  2  00 saw-up, 01 saw-down, 10 triangle, 11 single-shot up
cfg_lo  in  WIDTH  lower bound
cfg_hi  in  WIDTH  upper bound
start  in  1  level; sampled each clock
stop  in  1  level; sampled each clock
count  out  WIDTH  current count value
dir  out  1  0 = counting up, 1 = counting down
busy  out  1  high in RUN or HOLD
wrap  out  1  one-clock pulse on every wrap, turnaround or single-shot completion
cfg_err  out  1  sticky; set by a rejected configuration, cleared by the next accepted one

Behaviour:
- Reset is asynchronous, active-low (rst_n), clock is clock.
- Reset values:
  - state IDLE; count 0; dir 0; busy 0; wrap 0; cfg_err 0.
  - Stored config: mode 00, lo 0, hi 2^WIDTH-1; prescaler 0; hold counter 0.
- States: IDLE, RUN, HOLD, DONE.
- cfg_ready = 1 only in IDLE.
- Handshake: cfg_valid && cfg_ready completes in one cycle.
  - If cfg_lo <= cfg_hi: capture mode/lo/hi, clear cfg_err.
  - Otherwise: keep the old config, set cfg_err.
- IDLE -> RUN on start && !stop.
  - Count loads hi for mode 01, lo for all other modes.
  - dir = 1 for mode 01, 0 otherwise.
  - Prescaler clears. The first step tick comes TICK_DIV clocks later.
- Prescaler runs only in RUN/HOLD. A tick is one clock when the prescaler reaches TICK_DIV-1; it then returns to 0.
- In RUN, on a tick:
  - Mode 00: count < hi -> count+1; count == hi -> count = lo, pulse wrap.
  - Mode 01: count > lo -> count-1; count == lo -> count = hi, pulse wrap.
  - Mode 10, at the endpoint in the current direction:
    - Toggle dir and pulse wrap.
    - If HOLD_TICKS > 0: go to HOLD with the hold counter at 0.
    - Otherwise: step once in the new direction on the same tick.
  - Mode 10, not at an endpoint: step by ±1 per dir.
  - Mode 11: count < hi -> count+1; count == hi -> pulse wrap, go to DONE.
- HOLD: count frozen; the hold counter increments per tick. On the HOLD_TICKS-th tick, return to RUN with no step on that tick.
- DONE: count frozen at hi; busy = 0; stays until start or stop.
  - stop -> IDLE.
  - start && !stop -> reload as for IDLE -> RUN.
- stop in RUN/HOLD/DONE -> IDLE on the next edge. count and dir keep their values; prescaler clears.
- start and stop together: stop wins.
- start held high in RUN is ignored. There is no re-trigger except from IDLE/DONE.
- lo == hi:
  - Saw modes: count stays constant, wrap pulses every tick.
  - Triangle: dir toggles every endpoint event.
  - Single-shot: DONE on the first tick.
- Arithmetic is unsigned WIDTH-bit. Bounds keep it in range, so there is no natural overflow.
- Reset mid-sweep returns immediately to the reset values. Stored config also reverts to defaults.
- wrap is registered and coincides with the count update edge.

Decomposition:
- Shared package counter_pkg:
  - State enum (IDLE/RUN/HOLD/DONE).
  - Mode constants MODE_SAW_UP=2'b00, MODE_SAW_DN=2'b01, MODE_TRI=2'b10, MODE_ONESHOT=2'b11.
  - Default-bound constants.
- Sub-module tick_gen: the prescaler with a clear input, parameter TICK_DIV, and a one-clock tick output. It is reused by other board demos.
- The FSM, step logic and config registers stay in counter_sweep_ctrl.

Test Plan (TICK_DIV=2, HOLD_TICKS=2):
1. Config mode 00, lo 3, hi 5; start -> count 3,4,5,3,4 on successive ticks; wrap pulses on the 5->3 tick; busy=1.
2. Config mode 10, lo 0, hi 2 -> sequence:
   - Ticks 1-2: count 0,1,2.
   - Tick 3 (count==hi): wrap pulses, dir goes to 1, HOLD entered.
   - HOLD for 2 ticks with count 2.
   - Then count 1,0; HOLD at 0 with dir returning to 0.
3. cfg_lo 9, cfg_hi 4 with cfg_valid in IDLE -> cfg_err=1, old config kept. Then a valid config (lo 0, hi 1) -> cfg_err=0.
4. cfg_valid during RUN -> cfg_ready=0, nothing captured. start+stop in the same cycle from IDLE -> stays IDLE, count unchanged.
5. Mode 11, lo 62, hi 63 -> count 62,63; wrap pulses and DONE is entered on the 63 tick; busy=0, count holds 63. stop -> IDLE.
6. rst_n low for 1 ns mid-RUN at count 4, dir 1 -> immediately count 0, dir 0, IDLE, config back to lo 0, hi 63, mode 00.
